// File: rtl/hop_sel_pkg.sv
// Shared constants, butterfly pair tables, bank mapping and FSM states for the hop-selection kernel.
// Pure declarations; no timing or flow control.
package hop_sel_pkg;

  localparam int CH_NUM   = 79;
  localparam int AFH_NMIN = 20;

  // Element k is the bit pair swapped by control bit P[k]; P13 is applied first.
  localparam logic [2:0] BF_I [14] = '{3'd0, 3'd2, 3'd1, 3'd3, 3'd0, 3'd1, 3'd0,
                                       3'd3, 3'd1, 3'd0, 3'd2, 3'd1, 3'd0, 3'd1};
  localparam logic [2:0] BF_J [14] = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd4, 3'd3, 3'd2,
                                       3'd4, 3'd4, 3'd3, 3'd4, 3'd3, 3'd3, 3'd2};

  typedef enum logic [2:0] {IDLE, PERM, MOD, CHK, SCAN} state_t;

  // Register-bank order: even channels first, then odd ones.
  function automatic logic [6:0] bank_ch(input logic [6:0] k);
    logic [6:0] t;
    t = (k < 7'd40) ? k : k - 7'd40;
    return (k < 7'd40) ? {t[5:0], 1'b0} : {t[5:0], 1'b1};
  endfunction

endpackage

// File: rtl/hop_sel_perm.sv
// Combinational 5-bit, 14-stage butterfly permutation; zero latency.
// No flow control; output follows inputs.
module hop_sel_perm
  import hop_sel_pkg::*;
(
  input  logic [4:0]  z,
  input  logic [13:0] p,
  output logic [4:0]  perm
);

  logic [4:0] v;
  logic       t;

  always_comb begin
    v = z;
    t = 1'b0;
    for (int k = 13; k >= 0; k--) begin
      if (p[k]) begin
        t           = v[BF_I[k]];
        v[BF_I[k]]  = v[BF_J[k]];
        v[BF_J[k]]  = t;
      end
    end
    perm = v;
  end

endmodule

// File: rtl/hop_sel_kernel.sv
// BR/EDR hop selection with AFH remap; hop_done 4+m cycles after hop_start, plus 1+idx on a remap scan.
// Single outstanding request: hop_start is ignored while busy.
module hop_sel_kernel
  import hop_sel_pkg::*;
(
  input  logic        clk_6M,
  input  logic        rst,
  input  logic        hop_start,
  input  logic [4:0]  X,
  input  logic        Y1,
  input  logic [5:0]  Y2,
  input  logic [4:0]  A,
  input  logic [3:0]  B,
  input  logic [4:0]  C,
  input  logic [8:0]  D,
  input  logic [6:0]  E,
  input  logic [6:0]  F,
  input  logic [6:0]  Fprime,
  input  logic        conns,
  input  logic        afh_en,
  input  logic [6:0]  afh_N,
  input  logic [78:0] afh_map,
  output logic        busy,
  output logic        hop_done,
  output logic [6:0]  hop_chan,
  output logic        afh_err
);

  state_t      state;
  logic [4:0]  cw_x, cw_a, cw_c;
  logic        cw_y1;
  logic [5:0]  cw_y2;
  logic [3:0]  cw_b;
  logic [8:0]  cw_d;
  logic [6:0]  cw_e, cw_f, cw_fp;
  logic        afh_act;
  logic [6:0]  afh_n;
  logic [78:0] map;
  logic [8:0]  s1, s2;
  logic [6:0]  ch, idx, cnt;

  logic [4:0]  zsum, z, perm;
  logic [13:0] p;
  logic        s1_rdy, s2_rdy;
  logic [6:0]  chk_ch, scan_ch;
  logic        scan_hit;

  assign zsum     = cw_x + cw_a;
  assign z        = {zsum[4], zsum[3:0] ^ cw_b};
  assign p        = {cw_c ^ {5{cw_y1}}, cw_d};
  assign s1_rdy   = s1 < 9'd79;
  assign s2_rdy   = !afh_act || (s2 < {2'b00, afh_n});
  assign chk_ch   = bank_ch(s1[6:0]);
  assign scan_ch  = bank_ch(idx);
  assign scan_hit = map[scan_ch] && ({2'b00, cnt} == s2);

  hop_sel_perm u_perm (
    .z    (z),
    .p    (p),
    .perm (perm)
  );

  always_ff @(posedge clk_6M) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      hop_done <= 1'b0;
      hop_chan <= '0;
      afh_err  <= 1'b0;
      cw_x     <= '0;  cw_y1 <= 1'b0; cw_y2 <= '0; cw_a <= '0; cw_b <= '0;
      cw_c     <= '0;  cw_d  <= '0;   cw_e  <= '0; cw_f <= '0; cw_fp <= '0;
      afh_act  <= 1'b0;
      afh_n    <= '0;
      map      <= '0;
      s1       <= '0;
      s2       <= '0;
      ch       <= '0;
      idx      <= '0;
      cnt      <= '0;
    end else begin
      hop_done <= 1'b0;
      afh_err  <= 1'b0;
      case (state)
        IDLE: begin
          busy <= hop_start;
          if (hop_start) begin
            cw_x  <= X;  cw_y1 <= Y1; cw_y2 <= Y2; cw_a <= A; cw_b <= B;
            cw_c  <= C;  cw_d  <= D;  cw_e  <= E;  cw_f <= F; cw_fp <= Fprime;
            afh_n <= afh_N;
            map   <= afh_map;
            afh_act <= conns && afh_en && (afh_N >= 7'(AFH_NMIN)) && (afh_N <= 7'(CH_NUM));
            state <= PERM;
          end
        end
        PERM: begin
          s1    <= {4'b0, perm} + {2'b0, cw_e} + {2'b0, cw_f}  + {3'b0, cw_y2};
          s2    <= {4'b0, perm} + {2'b0, cw_e} + {2'b0, cw_fp} + {3'b0, cw_y2};
          state <= MOD;
        end
        MOD: begin
          if (s1_rdy && s2_rdy) begin
            state <= CHK;
          end else begin
            if (!s1_rdy) s1 <= s1 - 9'd79;
            if (!s2_rdy) s2 <= s2 - {2'b00, afh_n};
          end
        end
        CHK: begin
          if (!afh_act || map[chk_ch]) begin
            hop_chan <= chk_ch;
            hop_done <= 1'b1;
            state    <= IDLE;
          end else begin
            ch    <= chk_ch;
            idx   <= '0;
            cnt   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          idx <= idx + 7'd1;
          if (map[scan_ch] && !scan_hit) cnt <= cnt + 7'd1;
          if (scan_hit) begin
            hop_chan <= scan_ch;
            hop_done <= 1'b1;
            state    <= IDLE;
          end else if (idx == 7'(CH_NUM - 1)) begin
            // No used channel at the requested rank: keep the unmapped channel and flag it.
            hop_chan <= ch;
            hop_done <= 1'b1;
            afh_err  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/hop_sel_kernel.md
# hop_sel_kernel

Bluetooth BR/EDR hop-selection kernel (Core 5.1 Vol 2 Part B 2.6.2–2.6.3). Consumes the hopping control words X, Y1, Y2, A–F and F′ produced by the hop control-word generator and returns the RF channel index 0..78. Applies AFH remapping in connection state. Sits between the control-word generator and the RF synthesizer programming logic; one request per hop, multi-cycle, start/done handshake.

## Interface
- No parameters.
- `clk_6M`  in  1  system clock.
- `rst`  in  1  reset, synchronous to `clk_6M`, active-high.
- `hop_start`  in  1  one-cycle request pulse; samples all control-word inputs.
- `X`  in  5 / `Y1` in 1 / `Y2` in 6 / `A` in 5 / `B` in 4 / `C` in 5 / `D` in 9 / `E` in 7 / `F` in 7 / `Fprime` in 7  control words.
- `conns`  in  1  connection state; AFH applies only when set.
- `afh_en`  in  1  AFH enable.
- `afh_N`  in  7  number of used channels.
- `afh_map`  in  79  used-channel map, bit i = RF channel i.
- `busy`  out  1  request in progress.
- `hop_done`  out  1  one-cycle pulse; `hop_chan` valid.
- `hop_chan`  out  7  selected RF channel; held until next `hop_done`.
- `afh_err`  out  1  one-cycle pulse with `hop_done` when remap scan fails.

## Operation
- FSM states: IDLE, PERM, MOD, CHK, SCAN.
- IDLE: on `hop_start`, register all inputs. AFH is active only if `conns & afh_en` and 20 ≤ `afh_N` ≤ 79; otherwise non-AFH. Go to PERM.
- PERM:
  - Z = (X + A) mod 32; Z[3:0] ^= B.
  - Control word P[13:9] = C ^ {5{Y1}}, P[8:0] = D.
  - Butterflies run in order P13 first, P0 last. Each swaps bit pair (i,j) of Z when set:
    - P13 (1,2), P12 (0,3), P11 (1,3), P10 (2,4), P9 (0,3), P8 (1,4), P7 (3,4)
    - P6 (0,2), P5 (1,3), P4 (0,4), P3 (3,4), P2 (1,2), P1 (2,3), P0 (0,1)
  - Register s1 = perm + E + F + Y2 and s2 = perm + E + Fprime + Y2, both 9-bit unsigned (max 268). Go to MOD.
- MOD:
  - Each cycle: if s1 ≥ 79, s1 −= 79. If AFH is active and s2 ≥ `afh_N`, s2 −= `afh_N`.
  - Leave for CHK in the first cycle where both are already reduced; no subtraction happens in that cycle.
- Register-bank mapping: bank(k) = 2k for k < 40; 2(k−40)+1 for k ≥ 40.
- CHK:
  - ch = bank(s1).
  - If AFH is inactive or `afh_map[ch]`: finish with ch.
  - Otherwise clear idx and cnt, go to SCAN.
- SCAN (one bank index per cycle, idx 0..78):
  - If `afh_map[bank(idx)]`: when cnt == s2, finish with bank(idx); else cnt++.
  - If idx == 78 with no hit: finish with ch (unremapped) and pulse `afh_err`.
- Finish: register `hop_chan`, pulse `hop_done`, return to IDLE.
- `hop_start` while `busy` is ignored.
- `afh_map` and `afh_N` are sampled at `hop_start`.

## Timing
- Reset values: state IDLE, `busy` 0, `hop_done` 0, `hop_chan` 0, `afh_err` 0, all internal registers 0.
- `rst` mid-request aborts; there is no `hop_done` for the aborted request.
- `hop_start` at cycle T: `busy` high from T+1 until the cycle `hop_done` is high, inclusive.
- Latency, non-AFH or used channel: `hop_done` at T+4+m, where m = number of subtracting MOD cycles (0..3 for s1; up to 13 with s2).
- Latency, AFH remap: `hop_done` at T+5+m+idx_hit, where idx_hit is the bank index of the hit (78 on error).
- A new `hop_start` is accepted in the cycle after `hop_done` (state IDLE).

## Structure
- Package `hop_sel_pkg`:
  - constants CH_NUM = 79, AFH_NMIN = 20;
  - butterfly pair tables BF_I[14], BF_J[14];
  - function `bank_ch(k)`;
  - FSM state enum.
- Sub-module `hop_sel_perm`: combinational 5-bit, 14-stage butterfly network (inputs Z, P; output perm). Instanced once in the PERM stage.

## Test plan
- Basic: all control words 0 → `hop_chan` 0; `hop_done` exactly 4 cycles after `hop_start`; `busy` high for cycles 1..4.
- Bank mapping:
  - X=5, others 0 → ch 10.
  - E=45, others 0 → s1=45 → ch 11.
- Butterfly: X=1, D=9'h001, others 0 → perm 2 → ch 4. Also cover each Pi alone with a one-hot Z.
- Mod wrap: X=31, E=127, F=78, Y2=32 → s1=268 → 31 → ch 62; latency 7 cycles.
- AFH (conns=1, afh_en=1, even channels only used, N=40):
  - E=1 → ch 2 (no scan).
  - E=45 → ch 11 unused → s2=5 → ch 10, `afh_err` 0.
  - Map with fewer than 6 used channels, E=45 → `afh_err` pulse with `hop_chan` 11.
  - afh_N=10 → AFH bypassed → ch 11.
- Robustness:
  - `rst` during SCAN → outputs 0, no `hop_done`.
  - `hop_start` while busy → ignored, exactly one `hop_done`.
